// File: rtl/nanci_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nanci_sort_ctrl
// Purpose  : Shearsort sequencer for the Nanci PE mesh; broadcasts per-step
//            axis/parity/snake commands and a start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module nanci_sort_ctrl #(
    parameter int SIDE        = 4,
    parameter int ITER        = 2,
    parameter int STEP_CYCLES = 1,
    parameter int ROW_MAJOR   = 0,
    localparam int PW         = $clog2(2*ITER+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_abort,
    output logic          o_busy,
    output logic          o_load,
    output logic          o_step_en,
    output logic          o_axis,
    output logic          o_parity,
    output logic          o_snake,
    output logic [PW-1:0] o_phase,
    output logic          o_done
);

    localparam int SW = (SIDE > 1) ? $clog2(SIDE) : 1;
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_LOAD = 2'd1;
    localparam logic [1:0] C_SORT = 2'd2;
    localparam logic [1:0] C_DONE = 2'd3;

    localparam logic [CW-1:0] C_CYC_LAST   = CW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0] C_STEP_LAST  = SW'(SIDE - 1);
    localparam logic [PW-1:0] C_PHASE_LAST = PW'(2 * ITER);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cyc;
    logic [SW-1:0] r_step;
    logic [PW-1:0] r_phase;

    logic [1:0]    w_next_state;
    logic [CW-1:0] w_next_cyc;
    logic [SW-1:0] w_next_step;
    logic [PW-1:0] w_next_phase;

    logic          w_busy;
    logic          w_load;
    logic          w_step_en;
    logic          w_axis;
    logic          w_parity;
    logic          w_snake;
    logic [PW-1:0] w_phase;
    logic          w_done;

    // State, counters and outputs all register together so outputs line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= C_IDLE;
            r_cyc     <= '0;
            r_step    <= '0;
            r_phase   <= '0;
            o_busy    <= 1'b0;
            o_load    <= 1'b0;
            o_step_en <= 1'b0;
            o_axis    <= 1'b0;
            o_parity  <= 1'b0;
            o_snake   <= 1'b0;
            o_phase   <= '0;
            o_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cyc     <= w_next_cyc;
            r_step    <= w_next_step;
            r_phase   <= w_next_phase;
            o_busy    <= w_busy;
            o_load    <= w_load;
            o_step_en <= w_step_en;
            o_axis    <= w_axis;
            o_parity  <= w_parity;
            o_snake   <= w_snake;
            o_phase   <= w_phase;
            o_done    <= w_done;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cyc   = '0;
        w_next_step  = '0;
        w_next_phase = '0;
        if (i_abort) begin
            w_next_state = C_IDLE;
        end else begin
            case (r_state)
                C_IDLE: if (i_start) w_next_state = C_LOAD;
                C_LOAD: w_next_state = C_SORT;
                C_SORT: begin
                    w_next_cyc   = r_cyc;
                    w_next_step  = r_step;
                    w_next_phase = r_phase;
                    if (r_cyc != C_CYC_LAST) begin
                        w_next_cyc = r_cyc + 1'b1;
                    end else begin
                        w_next_cyc = '0;
                        if (r_step != C_STEP_LAST) begin
                            w_next_step = r_step + 1'b1;
                        end else begin
                            w_next_step = '0;
                            if (r_phase != C_PHASE_LAST) begin
                                w_next_phase = r_phase + 1'b1;
                            end else begin
                                w_next_phase = '0;
                                w_next_state = C_DONE;
                            end
                        end
                    end
                end
                default: w_next_state = C_IDLE;
            endcase
        end
    end

    // Outputs decode the upcoming state/counters so they register in step.
    always_comb begin
        w_busy    = (w_next_state != C_IDLE);
        w_load    = (w_next_state == C_LOAD);
        w_done    = (w_next_state == C_DONE);
        w_step_en = 1'b0;
        w_axis    = 1'b0;
        w_parity  = 1'b0;
        w_snake   = 1'b0;
        w_phase   = '0;
        if (w_next_state == C_SORT) begin
            w_step_en = (w_next_cyc == '0);
            w_axis    = w_next_phase[0];
            w_parity  = w_next_step[0];
            w_snake   = !w_next_phase[0] &&
                        !((ROW_MAJOR != 0) && (w_next_phase == C_PHASE_LAST));
            w_phase   = w_next_phase;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nanci_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nanci_sort_ctrl
// Purpose  : Directed self-checking bench for nanci_sort_ctrl (three configs).
// Revision : 1.0
// ============================================================================
module tb_nanci_sort_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;

    int errors = 0;
    int checks = 0;

    // Packed view: {busy, load, step_en, axis, parity, snake, phase[2:0], done}
    logic       n_busy, n_load, n_en, n_axis, n_par, n_snake, n_done;
    logic [2:0] n_phase;
    logic       r_busy, r_load, r_en, r_axis, r_par, r_snake, r_done;
    logic [2:0] r_phase;
    logic       s_busy, s_load, s_en, s_axis, s_par, s_snake, s_done;
    logic [2:0] s_phase;

    wire [9:0] nom_vec = {n_busy, n_load, n_en, n_axis, n_par, n_snake, n_phase, n_done};
    wire [9:0] rm_vec  = {r_busy, r_load, r_en, r_axis, r_par, r_snake, r_phase, r_done};
    wire [9:0] s3_vec  = {s_busy, s_load, s_en, s_axis, s_par, s_snake, s_phase, s_done};

    always #5 clk = ~clk;

    nanci_sort_ctrl #(.SIDE(4), .ITER(2), .STEP_CYCLES(1), .ROW_MAJOR(0)) u_nom (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
        .o_busy(n_busy), .o_load(n_load), .o_step_en(n_en), .o_axis(n_axis),
        .o_parity(n_par), .o_snake(n_snake), .o_phase(n_phase), .o_done(n_done));

    nanci_sort_ctrl #(.SIDE(4), .ITER(2), .STEP_CYCLES(1), .ROW_MAJOR(1)) u_rm (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
        .o_busy(r_busy), .o_load(r_load), .o_step_en(r_en), .o_axis(r_axis),
        .o_parity(r_par), .o_snake(r_snake), .o_phase(r_phase), .o_done(r_done));

    nanci_sort_ctrl #(.SIDE(4), .ITER(2), .STEP_CYCLES(3), .ROW_MAJOR(0)) u_s3 (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
        .o_busy(s_busy), .o_load(s_load), .o_step_en(s_en), .o_axis(s_axis),
        .o_parity(s_par), .o_snake(s_snake), .o_phase(s_phase), .o_done(s_done));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs j cycles after the start-sampling edge, STEP_CYCLES=1.
    function automatic logic [9:0] exp_one(input int j, input bit rm);
        int s, ph, st;
        bit sn;
        if (j == 1) return 10'b11_0000_000_0;
        if (j >= 2 && j <= 21) begin
            s  = j - 2;
            ph = s / 4;
            st = s % 4;
            sn = (ph % 2 == 0) && !(rm && ph == 4);
            return {1'b1, 1'b0, 1'b1, 1'(ph % 2), 1'(st % 2), sn, 3'(ph), 1'b0};
        end
        if (j == 22) return 10'b10_0000_000_1;
        return 10'd0;
    endfunction

    function automatic logic [9:0] exp_three(input int j);
        int s, ph, st;
        if (j == 1) return 10'b11_0000_000_0;
        if (j >= 2 && j <= 61) begin
            s  = j - 2;
            ph = s / 12;
            st = (s / 3) % 4;
            return {1'b1, 1'b0, 1'(s % 3 == 0), 1'(ph % 2), 1'(st % 2),
                    1'(ph % 2 == 0), 3'(ph), 1'b0};
        end
        if (j == 62) return 10'b10_0000_000_1;
        return 10'd0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Nominal run; optionally pulses start inside SORT and on the DONE cycle.
    task automatic run_nom(input bit inject, input bit chk_rm);
        int dones;
        dones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 25; j++) begin
            check($sformatf("nom j=%0d", j), 32'(nom_vec), 32'(exp_one(j, 1'b0)));
            if (chk_rm)
                check($sformatf("rowmajor j=%0d", j), 32'(rm_vec), 32'(exp_one(j, 1'b1)));
            if (n_done) dones++;
            start = inject && (j == 10 || j == 22);
            tick();
        end
        start = 1'b0;
        check("nom done count", 32'(dones), 32'd1);
    endtask

    initial begin
        // Reset state
        tick();
        check("reset nom", 32'(nom_vec), 32'd0);
        check("reset rm",  32'(rm_vec),  32'd0);
        check("reset s3",  32'(s3_vec),  32'd0);
        rst = 1'b0;
        tick();

        // Nominal + row-major + ignored starts
        run_nom(1'b1, 1'b1);

        // STEP_CYCLES=3 timing
        do_reset();
        begin
            int pulses;
            pulses = 0;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int j = 1; j <= 64; j++) begin
                check($sformatf("s3 j=%0d", j), 32'(s3_vec), 32'(exp_three(j)));
                if (s_en) pulses++;
                tick();
            end
            check("s3 step_en pulses", 32'(pulses), 32'd20);
        end

        // Abort during phase 2, then a clean run
        do_reset();
        begin
            int dones;
            dones = 0;
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int j = 1; j <= 12; j++) tick();
            check("abort pre phase", 32'(n_phase), 32'd2);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort next cycle", 32'(nom_vec), 32'd0);
            for (int j = 0; j < 15; j++) begin
                if (n_done || n_busy) dones++;
                tick();
            end
            check("abort stays idle", 32'(dones), 32'd0);
        end
        run_nom(1'b0, 1'b0);

        // Reset mid-SORT
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j < 8; j++) tick();
        check("pre-rst busy", 32'(n_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst mid sort", 32'(nom_vec), 32'd0);
        tick();
        check("rst stays idle", 32'(nom_vec), 32'd0);

        // start together with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start+abort load", 32'(n_load), 32'd0);
        check("start+abort vec", 32'(nom_vec), 32'd0);
        tick();
        check("start+abort after", 32'(nom_vec), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nanci_sort_ctrl.md
Name: nanci_sort_ctrl

Overview:
- Central sequencer for the Nanci PE mesh.
- Runs a shearsort schedule over a SIDE x SIDE grid of PEs. Each phase is either a snake-row or a column odd-even transposition sort.
- Broadcasts per-cycle step commands: axis, pair parity and direction. Each PE combines these with its row/column index and FIRST_IN_ROW to select its l/r/u/d partner.
- Provides a start/busy/done handshake to the host and a load pulse that triggers PE memory load.

Parameters:
- SIDE, 4, mesh side length in PEs; power of two, >= 2.
- ITER, 2, number of (row phase, column phase) pairs; log2(SIDE) for a full sort.
- STEP_CYCLES, 1, clock cycles per compare-exchange step; equals the PE SORT_CYCLES value; >= 1.
- ROW_MAJOR, 0, 1 = final row phase is non-snake (all rows ascending); 0 = snake on every row phase.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- i_start  in  1  request a sort; sampled in IDLE only.
- i_abort  in  1  synchronous abort; returns to IDLE, no done.
- o_busy  out  1  high from the LOAD cycle through the DONE cycle inclusive.
- o_load  out  1  one-cycle pulse: PEs load their memory word.
- o_step_en  out  1  high on the first cycle of each step: PEs capture the exchange result.
- o_axis  out  1  0 = row phase (l/r partners); 1 = column phase (u/d partners).
- o_parity  out  1  0 = even pairs (0-1, 2-3, ...); 1 = odd pairs (1-2, 3-4, ...).
- o_snake  out  1  row phases only: odd rows sort descending; 0 in column phases.
- o_phase  out  clog2(2*ITER+1)  index of the current phase, 0..2*ITER.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; all counters 0.
- FSM states are IDLE, LOAD, SORT and DONE.
- IDLE: if i_start = 1 at an edge, the next cycle is LOAD. No other transitions out of IDLE.
- LOAD: lasts exactly 1 cycle. o_load = 1 and o_busy = 1. The next state is SORT with phase 0, step 0, parity 0.
- SORT: runs 2*ITER+1 phases.
  - Even phase index: row phase. Odd phase index: column phase.
  - The last phase (index 2*ITER) is a row phase.
  - Each phase has SIDE steps. Each step lasts STEP_CYCLES cycles.
  - o_step_en = 1 only on a step's first cycle.
  - o_parity = step index mod 2, so it restarts at 0 in each phase.
  - o_snake = 1 in row phases, except the final phase when ROW_MAJOR = 1.
  - o_axis and o_phase are held constant for the whole phase.
- Cycle counter: counts 0..STEP_CYCLES-1 and wraps to 0. On wrap, the step counter increments.
- Step counter: counts 0..SIDE-1. On wrap, the phase counter increments.
- Phase counter: when it wraps past 2*ITER, the next state is DONE.
- SORT length: exactly (2*ITER+1)*SIDE*STEP_CYCLES cycles.
- DONE: lasts 1 cycle. o_done = 1, o_busy = 1, and o_step_en = 0. The next state is IDLE.
- i_start while not in IDLE: ignored, with no queuing. i_start high in the DONE cycle is also ignored.
- i_start held high continuously: a new sort begins on the first IDLE cycle, so there is exactly one idle cycle between runs.
- i_abort in any state: takes priority over everything. The next cycle is IDLE with all outputs 0 and counters cleared. o_done is never asserted for an aborted run.
- i_abort and i_start together in IDLE: the FSM stays in IDLE.
- rst asserted mid-operation: identical to i_abort and also has priority over it. Reset state is reached on the next edge.
- Outside SORT: o_step_en, o_axis, o_parity, o_snake and o_phase are all 0.

Test Plan:
1. Nominal run (SIDE=4, ITER=2, STEP_CYCLES=1). Pulse i_start at edge k.
   - o_load=1 and o_busy rises at k+1.
   - o_step_en=1 on 20 consecutive cycles, k+2..k+21.
   - o_done=1 at k+22; o_busy falls at k+23.
2. Phase/parity sequence for the same run.
   - o_phase steps 0,1,2,3,4 every 4 cycles.
   - o_axis pattern: 0,1,0,1,0.
   - o_parity pattern in every phase: 0,1,0,1.
   - o_snake=1 only in phases 0, 2 and 4.
   - Repeat with ROW_MAJOR=1: o_snake=0 in phase 4.
3. STEP_CYCLES=3 run.
   - o_step_en is high every 3rd cycle, 20 pulses total.
   - SORT lasts 60 cycles; o_done at k+62.
4. Ignored start.
   - Pulse i_start at k+10 and at k+22 (the DONE cycle).
   - No restart; exactly one o_done per run.
5. Abort at k+12 during phase 2.
   - Next cycle: all outputs 0, state IDLE, no o_done.
   - A fresh i_start then completes the full nominal timing.
6. Reset during SORT, and simultaneous inputs.
   - rst at k+8: outputs go to 0 on the following cycle.
   - i_start together with i_abort in IDLE: o_load stays 0.
